lvds_cal_ctrl: RTL and testbench
================================

Name: lvds_cal_ctrl

Overview:
Word-alignment calibration sequencer for the 11-lane LVDS DDR receiver in the camera receive path. It waits for the receiver's ready flag, lets the deserialiser settle, then compares the deserialised word to the known training pattern. On mismatch it issues bit-slip (word-align) pulses. After too many slips it resets the PHY. It reports lock and diagnostic counters. It runs in the receiver's recovered parallel clock domain and gates the AXIS buffer via o_cal_done.

Parameters:
DWIDTH, 88, deserialised word width (8 bits x 11 lanes).
CAL_PATTERN, 88'h005A55FEDCBA9876543210, training word expected when aligned.
SETTLE_CYC, 16, cycles to wait after ready or after each align pulse before comparing (>=2).
MATCH_CNT, 4, consecutive pattern matches required to declare lock (>=1).
MAX_SLIPS, 32, align pulses per attempt before a PHY reset (<=63).
RST_CYC, 8, width of the o_phy_rst pulse in cycles (>=1).

Ports:
i_clk  in  1  receiver parallel (recovered) clock
i_arst_n  in  1  asynchronous active-low reset
i_rx_ready  in  1  deserialiser ready/locked flag, synchronous to i_clk
i_rx_data  in  DWIDTH  deserialised word, valid every cycle
i_recal  in  1  single-cycle request to drop lock and recalibrate
o_align  out  1  one-cycle word-align (bit-slip) pulse to the deserialiser
o_phy_rst  out  1  deserialiser/calibration reset request
o_cal_done  out  1  lock flag; high only in LOCKED
o_state  out  3  current FSM encoding
o_slip_cnt  out  6  align pulses issued in the current attempt
o_fail_cnt  out  8  PHY resets issued since reset; saturates at 255

Behaviour:
- Reset (i_arst_n low, asynchronous): state=IDLE. All outputs 0. Internal settle, match and reset counters 0. Reset takes effect immediately in any state, including mid-SLIP and mid-PHYRST.
- All outputs are registered. o_state encoding: IDLE=0, SETTLE=1, CHECK=2, SLIP=3, PHYRST=4, LOCKED=5. Encodings 6 and 7 return to IDLE on the next cycle.
- IDLE: slip_cnt<=0, match_cnt<=0. Go to SETTLE when i_rx_ready=1.
- SETTLE: the settle counter counts from 0. When it reaches SETTLE_CYC-1, go to CHECK. Settle counter clears on entry.
- CHECK: evaluated on each cycle i_rx_data is sampled.
  - If i_rx_data==CAL_PATTERN: match_cnt++. When match_cnt reaches MATCH_CNT, go to LOCKED on that same edge.
  - If i_rx_data==0 (link idle): match_cnt<=0, remain in CHECK, no slip.
  - Otherwise (nonzero mismatch): match_cnt<=0, go to SLIP.
- SLIP: o_align=1 for exactly this one cycle. slip_cnt++.
  - If slip_cnt (after increment) == MAX_SLIPS, go to PHYRST.
  - Otherwise go to SETTLE.
  - Consecutive o_align pulses are therefore at least SETTLE_CYC+2 cycles apart.
- PHYRST: o_phy_rst=1 for exactly RST_CYC cycles. fail_cnt++ once on entry, saturating at 255. slip_cnt<=0. Then go to IDLE. i_rx_ready and i_recal are ignored in this state.
- LOCKED: o_cal_done=1. On i_recal=1 or i_rx_ready=0, go to IDLE; o_cal_done is low in the following cycle. Data content is not monitored while locked.
- i_rx_ready=0 in SETTLE, CHECK or SLIP: go to IDLE next cycle. No o_align is issued on that edge. slip_cnt and match_cnt clear.
- i_recal in SETTLE, CHECK or SLIP: same as ready loss. i_recal in IDLE: no effect.
- Priority on simultaneous events: async reset > i_rx_ready loss > i_recal > pattern compare.
- o_slip_cnt holds its value in LOCKED for diagnostics. It clears on entry to IDLE or PHYRST.
- o_fail_cnt clears only on reset.
- Implementation is a single always_ff FSM plus counters, target 150-250 lines.

Test Plan:
- Aligned link: i_rx_ready rises, i_rx_data=CAL_PATTERN constantly -> CHECK entered 16 cycles after SETTLE entry; o_cal_done=1 after 4 matches; o_align never pulses; o_slip_cnt=0.
- Three-slip lock: bench rotates the word per o_align until the 3rd pulse, then presents CAL_PATTERN -> exactly 3 one-cycle o_align pulses, each >=18 cycles apart; lock reached; o_slip_cnt=3.
- Never aligns: constant 88'h1 -> 32 o_align pulses, then o_phy_rst high exactly 8 cycles, o_fail_cnt=1, state returns to IDLE; repeated 300 attempts -> o_fail_cnt stays 255.
- Broken match run / idle data: 2 matches, one 0 word, then 4 matches -> lock with no o_align. Separately, 2 matches then 88'hFF -> one o_align, o_slip_cnt=1.
- Lock loss: in LOCKED, drop i_rx_ready for 1 cycle -> o_cal_done low next cycle, IDLE. Repeat with an i_recal pulse -> same. i_recal during PHYRST -> o_phy_rst still 8 cycles.
- Async reset: assert i_arst_n low mid-SLIP and mid-PHYRST -> o_align, o_phy_rst, o_cal_done and all counters 0 immediately, without a clock edge; o_state=0.

Source files
------------

// File: rtl/lvds_cal_ctrl_if.sv
// Bundle of the receiver-facing signals of the LVDS word-alignment
// calibration sequencer. The controller uses the slave modport; the
// receiver model (or the deserialiser wrapper) uses the master modport.
interface lvds_cal_ctrl_if #(
  parameter int DWIDTH = 88
);
  logic              i_rx_ready;
  logic [DWIDTH-1:0] i_rx_data;
  logic              i_recal;
  logic              o_align;
  logic              o_phy_rst;
  logic              o_cal_done;
  logic [2:0]        o_state;
  logic [5:0]        o_slip_cnt;
  logic [7:0]        o_fail_cnt;

  modport master (
    output i_rx_ready,
    output i_rx_data,
    output i_recal,
    input  o_align,
    input  o_phy_rst,
    input  o_cal_done,
    input  o_state,
    input  o_slip_cnt,
    input  o_fail_cnt
  );

  modport slave (
    input  i_rx_ready,
    input  i_rx_data,
    input  i_recal,
    output o_align,
    output o_phy_rst,
    output o_cal_done,
    output o_state,
    output o_slip_cnt,
    output o_fail_cnt
  );
endinterface

// File: rtl/lvds_cal_ctrl.sv
// Word-alignment calibration sequencer for the 11-lane LVDS DDR receiver.
// Waits for the deserialiser ready flag, lets the link settle, compares the
// deserialised word against the training pattern and issues bit-slip pulses
// until it sees MATCH_CNT consecutive matches. Too many slips in one attempt
// trigger a PHY reset. Runs in the recovered parallel clock domain; all
// outputs come straight from flops.
module lvds_cal_ctrl #(
  parameter int                DWIDTH      = 88,
  parameter logic [DWIDTH-1:0] CAL_PATTERN = 88'h005A55FEDCBA9876543210,
  parameter int                SETTLE_CYC  = 16,
  parameter int                MATCH_CNT   = 4,
  parameter int                MAX_SLIPS   = 32,
  parameter int                RST_CYC     = 8
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  lvds_cal_ctrl_if.slave     cal
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_PHYRST = 3'd4,
    ST_LOCKED = 3'd5
  } cal_state_e;

  // Counter widths sized to hold their terminal values.
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MATCH_GOAL  = MW'(MATCH_CNT);
  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYC - 1);
  localparam logic [5:0]    SLIP_LIMIT  = 6'(MAX_SLIPS);

  cal_state_e    state_q,  state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q,  match_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [5:0]    slip_q,   slip_d;
  logic [7:0]    fail_q,   fail_d;
  logic          align_q,  align_d;
  logic          phy_rst_q, phy_rst_d;
  logic          done_q,   done_d;

  logic          abort_s;
  logic          is_pattern_s;
  logic          is_idle_word_s;
  logic [MW-1:0] match_inc_s;
  logic [5:0]    slip_inc_s;

  // Ready loss outranks a recalibration request; both abandon the attempt.
  assign abort_s        = (~cal.i_rx_ready) | cal.i_recal;
  assign is_pattern_s   = (cal.i_rx_data == CAL_PATTERN);
  assign is_idle_word_s = (cal.i_rx_data == {DWIDTH{1'b0}});
  assign match_inc_s    = match_q + MW'(1);
  assign slip_inc_s     = slip_q + 6'd1;

  // Next-state and counter update logic for the calibration sequence.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    rst_cnt_d = rst_cnt_q;
    slip_d    = slip_q;
    fail_d    = fail_q;

    case (state_q)
      ST_IDLE: begin
        slip_d  = 6'd0;
        match_d = {MW{1'b0}};
        if (cal.i_rx_ready) begin
          state_d  = ST_SETTLE;
          settle_d = {SW{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          slip_d  = 6'd0;
          match_d = {MW{1'b0}};
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          match_d = {MW{1'b0}};
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_CHECK: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          slip_d  = 6'd0;
          match_d = {MW{1'b0}};
        end else if (is_pattern_s) begin
          match_d = match_inc_s;
          if (match_inc_s == MATCH_GOAL) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_CHECK;
          end
        end else if (is_idle_word_s) begin
          // Link idle: restart the match run but do not slip.
          match_d = {MW{1'b0}};
        end else begin
          match_d = {MW{1'b0}};
          state_d = ST_SLIP;
        end
      end

      ST_SLIP: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          slip_d  = 6'd0;
          match_d = {MW{1'b0}};
        end else if (slip_inc_s == SLIP_LIMIT) begin
          state_d   = ST_PHYRST;
          slip_d    = 6'd0;
          rst_cnt_d = {RW{1'b0}};
          fail_d    = (fail_q == 8'd255) ? fail_q : (fail_q + 8'd1);
        end else begin
          state_d  = ST_SETTLE;
          slip_d   = slip_inc_s;
          settle_d = {SW{1'b0}};
        end
      end

      ST_PHYRST: begin
        // Ready and recal are deliberately ignored until the pulse completes.
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      ST_LOCKED: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          slip_d  = 6'd0;
          match_d = {MW{1'b0}};
        end else begin
          state_d = ST_LOCKED;
        end
      end

      default: begin
        state_d = ST_IDLE;
        slip_d  = 6'd0;
        match_d = {MW{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the next state so they are valid in the
  // same cycle the state register shows the corresponding state.
  always_comb begin
    align_d   = (state_d == ST_SLIP);
    phy_rst_d = (state_d == ST_PHYRST);
    done_d    = (state_d == ST_LOCKED);
  end

  // State, counters and output flops with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= ST_IDLE;
      settle_q  <= {SW{1'b0}};
      match_q   <= {MW{1'b0}};
      rst_cnt_q <= {RW{1'b0}};
      slip_q    <= 6'd0;
      fail_q    <= 8'd0;
      align_q   <= 1'b0;
      phy_rst_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      rst_cnt_q <= rst_cnt_d;
      slip_q    <= slip_d;
      fail_q    <= fail_d;
      align_q   <= align_d;
      phy_rst_q <= phy_rst_d;
      done_q    <= done_d;
    end
  end

  assign cal.o_state    = state_q;
  assign cal.o_align    = align_q;
  assign cal.o_phy_rst  = phy_rst_q;
  assign cal.o_cal_done = done_q;
  assign cal.o_slip_cnt = slip_q;
  assign cal.o_fail_cnt = fail_q;

endmodule

// File: tb/tb_lvds_cal_ctrl.sv
// Self-checking bench for lvds_cal_ctrl. A closed-form schedule model
// predicts every output per cycle from the number of slips the link needs;
// a second, small-parameter instance exercises fail-counter saturation.
module tb_lvds_cal_ctrl;

  localparam int          DW     = 88;
  localparam logic [87:0] PAT    = 88'h005A55FEDCBA9876543210;
  localparam int          SETTLE = 16;
  localparam int          MATCH  = 4;
  localparam int          MAXS   = 32;
  localparam int          RSTC   = 8;
  localparam int          PER    = SETTLE + 2;

  typedef struct packed {
    logic [2:0] st;
    logic       al;
    logic       pr;
    logic       dn;
    logic [5:0] sl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_fail;

  lvds_cal_ctrl_if #(.DWIDTH(DW)) cal_if ();
  lvds_cal_ctrl_if #(.DWIDTH(DW)) sat_if ();

  lvds_cal_ctrl #(
    .DWIDTH(DW), .CAL_PATTERN(PAT), .SETTLE_CYC(SETTLE),
    .MATCH_CNT(MATCH), .MAX_SLIPS(MAXS), .RST_CYC(RSTC)
  ) u_dut (
    .i_clk(clk), .i_arst_n(rst_n), .cal(cal_if)
  );

  lvds_cal_ctrl #(
    .DWIDTH(DW), .CAL_PATTERN(PAT), .SETTLE_CYC(2),
    .MATCH_CNT(1), .MAX_SLIPS(1), .RST_CYC(1)
  ) u_sat (
    .i_clk(clk), .i_arst_n(rst_n), .cal(sat_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [87:0] rand_word();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[87:0];
  endfunction

  function automatic logic [87:0] rotl(input logic [87:0] w, input int n);
    return (w << n) | (w >> (88 - n));
  endfunction

  // Expected outputs at cycle c after ready rises (c=0 is the IDLE cycle in
  // which ready is first seen) when the link needs r slips to align.
  // Each failed compare costs one CHECK cycle, one SLIP cycle and a full
  // settle window; r >= MAXS means the link never aligns.
  function automatic exp_t model(input int c, input int r);
    exp_t e;
    int d, blk, off, nslip;
    e = '0;
    if (c == 0) begin
      e.st = 3'd0;
    end else if (c <= SETTLE) begin
      e.st = 3'd1;
    end else begin
      d     = c - SETTLE - 1;
      nslip = (r < MAXS) ? r : MAXS;
      blk   = d / PER;
      off   = d % PER;
      if (blk < nslip) begin
        e.sl = 6'(blk);
        if (off == 0) begin
          e.st = 3'd2;
        end else if (off == 1) begin
          e.st = 3'd3;
          e.al = 1'b1;
        end else if (blk == MAXS - 1) begin
          e.sl = 6'd0;
          if (off <= RSTC + 1) begin
            e.st = 3'd4;
            e.pr = 1'b1;
          end else begin
            e.st = 3'd0;
          end
        end else begin
          e.st = 3'd1;
          e.sl = 6'(blk + 1);
        end
      end else begin
        e.sl = 6'(r);
        if (d - PER * r < MATCH) begin
          e.st = 3'd2;
        end else begin
          e.st = 3'd5;
          e.dn = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // One calibration attempt against a deserialiser needing r slips.
  task automatic test_calibrate(input int r, input bit noisy, output int n_align, output int min_gap);
    exp_t e;
    logic [11:0] got;
    int misal, rot, last_c, phy_c, last_al, fexp;
    cal_if.i_rx_ready = 1'b0;
    cal_if.i_recal    = 1'b0;
    tick();
    tick();
    checks++;
    if (cal_if.o_state !== 3'd0) begin
      errors++;
      $display("FAIL calib_pre_idle r=%0d got state=%0d exp 0", r, cal_if.o_state);
    end
    rot     = $urandom_range(1, 87);
    misal   = r;
    n_align = 0;
    min_gap = 1000000;
    last_al = -1;
    phy_c   = SETTLE + 1 + PER * (MAXS - 1) + 2;
    last_c  = (r < MAXS) ? (SETTLE + 1 + PER * r + MATCH + 3) : (phy_c + RSTC);
    cal_if.i_rx_ready = 1'b1;
    cal_if.i_rx_data  = rand_word();
    for (int c = 1; c <= last_c; c++) begin
      tick();
      e    = model(c, r);
      fexp = (r >= MAXS && c >= phy_c) ? exp_fail + 1 : exp_fail;
      got  = {cal_if.o_state, cal_if.o_align, cal_if.o_phy_rst, cal_if.o_cal_done, cal_if.o_slip_cnt};
      checks++;
      if (got !== e || cal_if.o_fail_cnt !== 8'(fexp)) begin
        errors++;
        $display("FAIL calib r=%0d c=%0d got st=%0d al=%0b pr=%0b dn=%0b sl=%0d fl=%0d exp st=%0d al=%0b pr=%0b dn=%0b sl=%0d fl=%0d",
                 r, c, cal_if.o_state, cal_if.o_align, cal_if.o_phy_rst, cal_if.o_cal_done,
                 cal_if.o_slip_cnt, cal_if.o_fail_cnt, e.st, e.al, e.pr, e.dn, e.sl, fexp);
      end
      if (cal_if.o_align === 1'b1) begin
        n_align++;
        if (last_al >= 0 && (c - last_al) < min_gap) min_gap = c - last_al;
        last_al = c;
        if (misal > 0) misal--;
      end
      cal_if.i_rx_ready = 1'b1;
      cal_if.i_recal    = 1'b0;
      if (e.st == 3'd2) begin
        if (r >= MAXS) cal_if.i_rx_data = 88'h1;
        else if (misal == 0) cal_if.i_rx_data = PAT;
        else cal_if.i_rx_data = rotl(PAT, rot);
      end else begin
        cal_if.i_rx_data = rand_word();
      end
      if (e.st == 3'd4 && noisy) begin
        cal_if.i_rx_ready = 1'($urandom_range(0, 1));
        cal_if.i_recal    = 1'($urandom_range(0, 1));
      end
    end
    if (r >= MAXS) exp_fail = exp_fail + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    cal_if.i_rx_ready = 1'b0; cal_if.i_recal = 1'b0; cal_if.i_rx_data = '0;
    sat_if.i_rx_ready = 1'b0; sat_if.i_recal = 1'b0; sat_if.i_rx_data = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cal_if.o_state, cal_if.o_align, cal_if.o_phy_rst, cal_if.o_cal_done, cal_if.o_slip_cnt, cal_if.o_fail_cnt} !== 20'd0) begin
      errors++;
      $display("FAIL reset_async got st=%0d al=%0b pr=%0b dn=%0b sl=%0d fl=%0d exp all 0",
               cal_if.o_state, cal_if.o_align, cal_if.o_phy_rst, cal_if.o_cal_done, cal_if.o_slip_cnt, cal_if.o_fail_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    cal_if.i_rx_ready = 1'b1;
    checks++;
    if ({cal_if.o_state, cal_if.o_align, cal_if.o_phy_rst, cal_if.o_cal_done, cal_if.o_slip_cnt, cal_if.o_fail_cnt} !== 20'd0) begin
      errors++;
      $display("FAIL reset_held got st=%0d exp 0", cal_if.o_state);
    end
    cal_if.i_rx_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (cal_if.o_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle got state=%0d exp 0", cal_if.o_state);
    end
    exp_fail = 0;
  endtask

  task automatic test_aligned();
    int n, g;
    test_calibrate(0, 1'b0, n, g);
    checks++;
    if (n !== 0 || cal_if.o_slip_cnt !== 6'd0 || cal_if.o_cal_done !== 1'b1) begin
      errors++;
      $display("FAIL aligned got aligns=%0d slip=%0d done=%0b exp 0 0 1", n, cal_if.o_slip_cnt, cal_if.o_cal_done);
    end
  endtask

  task automatic test_three_slip();
    int n, g;
    test_calibrate(3, 1'b0, n, g);
    checks++;
    if (n !== 3 || g < PER || cal_if.o_slip_cnt !== 6'd3 || cal_if.o_cal_done !== 1'b1) begin
      errors++;
      $display("FAIL three_slip got aligns=%0d gap=%0d slip=%0d done=%0b exp 3 >=%0d 3 1",
               n, g, cal_if.o_slip_cnt, cal_if.o_cal_done, PER);
    end
  endtask

  task automatic test_random_slips();
    int n, g, r;
    for (int t = 0; t < 4; t++) begin
      r = $urandom_range(0, 6);
      test_calibrate(r, 1'b0, n, g);
      checks++;
      if (n !== r) begin
        errors++;
        $display("FAIL random_slips got aligns=%0d exp %0d", n, r);
      end
    end
  endtask

  task automatic test_never_aligns();
    int n, g;
    test_calibrate(MAXS, 1'b1, n, g);
    checks++;
    if (n !== MAXS || cal_if.o_fail_cnt !== 8'd1 || cal_if.o_state !== 3'd0) begin
      errors++;
      $display("FAIL never_aligns got aligns=%0d fail=%0d state=%0d exp %0d 1 0",
               n, cal_if.o_fail_cnt, cal_if.o_state, MAXS);
    end
  endtask

  task automatic test_broken_run();
    logic [2:0] est;
    logic       edn, eal;
    logic [5:0] esl;
    // Idle word inside a match run only restarts the run.
    cal_if.i_rx_ready = 1'b0; tick(); tick();
    cal_if.i_rx_ready = 1'b1; cal_if.i_rx_data = rand_word();
    for (int c = 1; c <= 26; c++) begin
      tick();
      est = (c <= 16) ? 3'd1 : ((c <= 23) ? 3'd2 : 3'd5);
      edn = (c >= 24);
      checks++;
      if ({cal_if.o_state, cal_if.o_align, cal_if.o_cal_done} !== {est, 1'b0, edn}) begin
        errors++;
        $display("FAIL broken_idle c=%0d got st=%0d al=%0b dn=%0b exp st=%0d al=0 dn=%0b",
                 c, cal_if.o_state, cal_if.o_align, cal_if.o_cal_done, est, edn);
      end
      if (c == 19) cal_if.i_rx_data = 88'h0;
      else if (c >= 17 && c <= 23) cal_if.i_rx_data = PAT;
      else cal_if.i_rx_data = rand_word();
    end
    // A nonzero mismatch after two matches slips once.
    cal_if.i_rx_ready = 1'b0; tick(); tick();
    cal_if.i_rx_ready = 1'b1; cal_if.i_rx_data = rand_word();
    for (int c = 1; c <= 22; c++) begin
      tick();
      est = (c <= 16) ? 3'd1 : ((c <= 19) ? 3'd2 : ((c == 20) ? 3'd3 : 3'd1));
      eal = (c == 20);
      esl = (c >= 21) ? 6'd1 : 6'd0;
      checks++;
      if ({cal_if.o_state, cal_if.o_align, cal_if.o_slip_cnt} !== {est, eal, esl}) begin
        errors++;
        $display("FAIL broken_ff c=%0d got st=%0d al=%0b sl=%0d exp st=%0d al=%0b sl=%0d",
                 c, cal_if.o_state, cal_if.o_align, cal_if.o_slip_cnt, est, eal, esl);
      end
      if (c == 17 || c == 18) cal_if.i_rx_data = PAT;
      else if (c == 19) cal_if.i_rx_data = 88'hFF;
      else cal_if.i_rx_data = rand_word();
    end
    cal_if.i_rx_ready = 1'b0; tick();
  endtask

  task automatic test_lock_loss();
    int n, g;
    logic [2:0] est;
    test_calibrate(0, 1'b0, n, g);
    cal_if.i_rx_data  = PAT;
    cal_if.i_rx_ready = 1'b0; tick(); cal_if.i_rx_ready = 1'b1;
    checks++;
    if ({cal_if.o_state, cal_if.o_cal_done, cal_if.o_slip_cnt} !== {3'd0, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL ready_loss got st=%0d dn=%0b sl=%0d exp 0 0 0", cal_if.o_state, cal_if.o_cal_done, cal_if.o_slip_cnt);
    end
    for (int c = 1; c <= 21; c++) begin
      tick();
      est = (c <= 16) ? 3'd1 : ((c <= 20) ? 3'd2 : 3'd5);
      checks++;
      if ({cal_if.o_state, cal_if.o_cal_done} !== {est, (c == 21)}) begin
        errors++;
        $display("FAIL relock c=%0d got st=%0d dn=%0b exp st=%0d", c, cal_if.o_state, cal_if.o_cal_done, est);
      end
    end
    cal_if.i_recal = 1'b1; tick(); cal_if.i_recal = 1'b0;
    checks++;
    if ({cal_if.o_state, cal_if.o_cal_done} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL recal_loss got st=%0d dn=%0b exp 0 0", cal_if.o_state, cal_if.o_cal_done);
    end
    cal_if.i_rx_ready = 1'b0; tick();
  endtask

  task automatic test_priority();
    cal_if.i_rx_ready = 1'b0; cal_if.i_recal = 1'b0; tick();
    // recal has no effect in IDLE
    cal_if.i_rx_ready = 1'b1; cal_if.i_recal = 1'b1; cal_if.i_rx_data = rand_word();
    tick(); cal_if.i_recal = 1'b0;
    checks++;
    if (cal_if.o_state !== 3'd1) begin
      errors++;
      $display("FAIL recal_idle got st=%0d exp 1", cal_if.o_state);
    end
    repeat (16) tick();
    checks++;
    if (cal_if.o_state !== 3'd2) begin
      errors++;
      $display("FAIL settle_len got st=%0d exp 2", cal_if.o_state);
    end
    // ready loss beats a mismatch: no align pulse
    cal_if.i_rx_data = 88'hFF; cal_if.i_rx_ready = 1'b0; tick();
    checks++;
    if ({cal_if.o_state, cal_if.o_align} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL ready_over_cmp got st=%0d al=%0b exp 0 0", cal_if.o_state, cal_if.o_align);
    end
    cal_if.i_rx_ready = 1'b1; repeat (17) tick();
    cal_if.i_rx_data = 88'hFF; cal_if.i_recal = 1'b1; tick(); cal_if.i_recal = 1'b0;
    checks++;
    if ({cal_if.o_state, cal_if.o_align} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL recal_over_cmp got st=%0d al=%0b exp 0 0", cal_if.o_state, cal_if.o_align);
    end
    tick(); tick();
    cal_if.i_recal = 1'b1; tick(); cal_if.i_recal = 1'b0;
    checks++;
    if (cal_if.o_state !== 3'd0) begin
      errors++;
      $display("FAIL recal_settle got st=%0d exp 0", cal_if.o_state);
    end
    cal_if.i_rx_ready = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    bit found;
    cal_if.i_rx_ready = 1'b1; cal_if.i_recal = 1'b0; cal_if.i_rx_data = 88'h1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (cal_if.o_align === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL slip_timeout got no align exp align within 100 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cal_if.o_state, cal_if.o_align, cal_if.o_phy_rst, cal_if.o_cal_done, cal_if.o_slip_cnt, cal_if.o_fail_cnt} !== 20'd0) begin
      errors++;
      $display("FAIL rst_mid_slip got st=%0d al=%0b sl=%0d exp all 0", cal_if.o_state, cal_if.o_align, cal_if.o_slip_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    exp_fail = 0;
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      tick();
      if (cal_if.o_phy_rst === 1'b1) found = 1'b1;
    end
    repeat (3) tick();
    checks++;
    if (!found || cal_if.o_phy_rst !== 1'b1 || cal_if.o_fail_cnt !== 8'd1) begin
      errors++;
      $display("FAIL phyrst_reach got found=%0b pr=%0b fl=%0d exp 1 1 1", found, cal_if.o_phy_rst, cal_if.o_fail_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cal_if.o_state, cal_if.o_align, cal_if.o_phy_rst, cal_if.o_cal_done, cal_if.o_slip_cnt, cal_if.o_fail_cnt} !== 20'd0) begin
      errors++;
      $display("FAIL rst_mid_phyrst got st=%0d pr=%0b fl=%0d exp all 0", cal_if.o_state, cal_if.o_phy_rst, cal_if.o_fail_cnt);
    end
    cal_if.i_rx_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_fail = 0;
    tick();
  endtask

  // Small instance: every attempt is one slip then a one-cycle PHY reset,
  // repeating every 6 cycles; 300 attempts must saturate at 255.
  task automatic test_fail_saturation();
    int ef;
    logic ep;
    sat_if.i_rx_ready = 1'b1; sat_if.i_recal = 1'b0; sat_if.i_rx_data = 88'h1;
    for (int c = 1; c <= 1850; c++) begin
      tick();
      ef = (c >= 5) ? ((c - 5) / 6 + 1) : 0;
      if (ef > 255) ef = 255;
      ep = (c >= 5) && ((c - 5) % 6 == 0);
      checks++;
      if (sat_if.o_fail_cnt !== 8'(ef) || sat_if.o_phy_rst !== ep) begin
        errors++;
        $display("FAIL fail_sat c=%0d got fl=%0d pr=%0b exp fl=%0d pr=%0b", c, sat_if.o_fail_cnt, sat_if.o_phy_rst, ef, ep);
      end
    end
    sat_if.i_rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_fail = 0;
    test_reset();
    test_aligned();
    test_three_slip();
    test_random_slips();
    test_broken_run();
    test_priority();
    test_lock_loss();
    test_never_aligns();
    test_async_reset();
    test_fail_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
